// File: rtl/hs32_fetch.sv
// HS32 instruction fetch: PC, one-outstanding memory read, prefetch FIFO to decode.
// Optional misaligned-redirect fault enabled by defining HS32_FETCH_ALIGN_FAULT_EN.
module hs32_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] newpc,
    input  logic        flush,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic        fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       state;
    logic [31:0]      pc;
    logic [31:0]      mem_addr_q;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      fifo_inst [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];

    logic [31:0] flush_pc;
    logic        push;
    logic        pop;
    logic        fetch_blocked;

    assign flush_pc = {newpc[31:2], 2'b00};

`ifdef HS32_FETCH_ALIGN_FAULT_EN
    logic fault_q;

    // Sticky until reset or an aligned redirect; while set no new fetch starts.
    always_ff @(posedge clk) begin
        if (reset)
            fault_q <= 1'b0;
        else if (flush)
            fault_q <= (newpc[1:0] != 2'b00);
    end

    assign fault         = fault_q;
    assign fetch_blocked = fault_q;
`else
    logic unused_newpc_lsb;

    assign unused_newpc_lsb = ^newpc[1:0];
    assign fault            = 1'b0;
    assign fetch_blocked    = 1'b0;
`endif

    // A redirect kills both the incoming word and any decode pop in the same edge.
    assign push       = (state == S_REQ) && mem_ack && !flush;
    assign pop        = inst_valid && inst_ready && !flush;
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            mem_addr_q <= RESET_PC;
        end else begin
            case (state)
                S_IDLE: begin
                    if (flush) begin
                        pc <= flush_pc;
                    end else if ((count < DEPTH_C) && !fetch_blocked) begin
                        state      <= S_REQ;
                        mem_addr_q <= pc;
                    end
                end
                S_REQ: begin
                    if (flush) begin
                        // The bus request cannot be withdrawn; drain it in DROP if still open.
                        pc    <= flush_pc;
                        state <= mem_ack ? S_IDLE : S_DROP;
                    end else if (mem_ack) begin
                        pc <= pc + 32'd4;
                        if (count_next < DEPTH_C)
                            mem_addr_q <= pc + 32'd4;
                        else
                            state <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (flush)
                        pc <= flush_pc;
                    if (mem_ack)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_next;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO storage has no reset; validity comes from count, and outputs are gated when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= pc;
        end
    end

    assign mem_req    = (state == S_REQ) || (state == S_DROP);
    assign mem_addr   = mem_addr_q;
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? fifo_inst[rd_ptr] : 32'h0;
    assign inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : 32'h0;

endmodule

// File: tb/tb_hs32_fetch.sv
// Directed self-checking bench for hs32_fetch: stream, stall, redirects, slow memory, PC wrap, fault.
module tb_hs32_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] newpc;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        fault;

    logic [31:0] w_addr;
    logic        w_req;
    logic [31:0] w_inst;
    logic [31:0] w_pc;
    logic        w_valid;
    logic        w_fault;

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 0;
    int wait_cnt = 0;
    logic [31:0] exp_pc;
    int cyc;

    hs32_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset), .newpc(newpc), .flush(flush),
        .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .fault(fault)
    );

    // Second instance only exercises PC wrap-around with an always-acking memory.
    hs32_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) u_wrap (
        .clk(clk), .reset(reset), .newpc(32'h0), .flush(1'b0),
        .mem_addr(w_addr), .mem_req(w_req), .mem_ack(w_req), .mem_rdata(~w_addr),
        .inst(w_inst), .inst_pc(w_pc), .inst_valid(w_valid), .inst_ready(1'b1),
        .fault(w_fault)
    );

    always #5 clk = ~clk;

    // Memory model: acks after lat cycles of a held request, data is the inverted address.
    assign mem_ack   = mem_req && (wait_cnt >= lat);
    assign mem_rdata = ~mem_addr;

    always @(posedge clk) begin
        if (reset || !mem_req || mem_ack)
            wait_cnt <= 0;
        else
            wait_cnt <= wait_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Consume n words in order starting at exp_pc; cyc returns negedges spent.
    task automatic expect_stream(input int n, input int budget, output int cyc_o);
        int got_n = 0;
        cyc_o = 0;
        while (got_n < n && cyc_o < budget) begin
            if (inst_valid && inst_ready) begin
                check("stream_pc", inst_pc, exp_pc);
                check("stream_inst", inst, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                got_n++;
            end
            @(negedge clk);
            cyc_o++;
        end
        check("stream_count", 32'(got_n), 32'(n));
    endtask

    task automatic wait_req(input int budget);
        int c = 0;
        while (!mem_req && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("req_seen", {31'b0, mem_req}, 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        clk        = 1'b0;
        reset      = 1'b1;
        flush      = 1'b0;
        newpc      = 32'h0;
        inst_ready = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_req",   {31'b0, mem_req}, 32'd0);
        check("rst_addr",  mem_addr, 32'h100);
        check("rst_valid", {31'b0, inst_valid}, 32'd0);
        check("rst_inst",  inst, 32'h0);
        check("rst_pc",    inst_pc, 32'h0);
        check("rst_fault", {31'b0, fault}, 32'd0);

        // Start-up and single-cycle-ack streaming
        reset = 1'b0;
        @(negedge clk);
        check("start_req",  {31'b0, mem_req}, 32'd1);
        check("start_addr", mem_addr, 32'h100);
        exp_pc = 32'h100;
        expect_stream(5, 20, cyc);
        check("throughput_cycles", 32'(cyc), 32'd6);

        // Decode stall: FIFO fills, request stops, stream resumes without loss
        inst_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("stall_req",   {31'b0, mem_req}, 32'd0);
        check("stall_valid", {31'b0, inst_valid}, 32'd1);
        check("stall_head",  inst_pc, exp_pc);
        inst_ready = 1'b1;
        expect_stream(4, 20, cyc);

        // Redirect while idle and full
        inst_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("full_idle_req", {31'b0, mem_req}, 32'd0);
        flush = 1'b1;
        newpc = 32'h200;
        @(negedge clk);
        flush = 1'b0;
        check("flush_valid", {31'b0, inst_valid}, 32'd0);
        check("flush_idle",  {31'b0, mem_req}, 32'd0);
        @(negedge clk);
        check("flush_req",  {31'b0, mem_req}, 32'd1);
        check("flush_addr", mem_addr, 32'h200);
        inst_ready = 1'b1;
        exp_pc = 32'h200;
        expect_stream(3, 20, cyc);

        // Slow memory: redirect one cycle into a pending request
        lat = 3;
        do_reset();
        @(negedge clk);
        check("slow_req",  {31'b0, mem_req}, 32'd1);
        check("slow_addr", mem_addr, 32'h100);
        @(negedge clk);
        flush = 1'b1;
        newpc = 32'h40;
        @(negedge clk);
        flush = 1'b0;
        check("drop_req",   {31'b0, mem_req}, 32'd1);
        check("drop_addr",  mem_addr, 32'h100);
        check("drop_valid", {31'b0, inst_valid}, 32'd0);
        @(negedge clk);
        check("drop_ack",      {31'b0, mem_ack}, 32'd1);
        check("drop_ack_addr", mem_addr, 32'h100);
        @(negedge clk);
        check("drop_discard", {31'b0, inst_valid}, 32'd0);
        wait_req(10);
        check("redir_addr", mem_addr, 32'h40);
        exp_pc = 32'h40;
        expect_stream(2, 40, cyc);

        // PC wrap on the second instance
        lat = 0;
        do_reset();
        begin
            logic [31:0] w_exp = 32'hFFFF_FFF8;
            int          w_n   = 0;
            for (int i = 0; i < 12 && w_n < 3; i++) begin
                @(negedge clk);
                if (w_valid) begin
                    check("wrap_pc", w_pc, w_exp);
                    w_exp = w_exp + 32'd4;
                    w_n++;
                end
            end
            check("wrap_count", 32'(w_n), 32'd3);
        end

        // Misaligned redirect
        flush = 1'b1;
        newpc = 32'h202;
        @(negedge clk);
        flush = 1'b0;
        check("mis_valid", {31'b0, inst_valid}, 32'd0);
`ifdef HS32_FETCH_ALIGN_FAULT_EN
        check("mis_fault", {31'b0, fault}, 32'd1);
        repeat (3) @(negedge clk);
        check("mis_noreq",  {31'b0, mem_req}, 32'd0);
        check("mis_sticky", {31'b0, fault}, 32'd1);
        flush = 1'b1;
        newpc = 32'h300;
        @(negedge clk);
        flush = 1'b0;
        check("fault_clear", {31'b0, fault}, 32'd0);
        wait_req(10);
        check("resume_addr", mem_addr, 32'h300);
        exp_pc = 32'h300;
`else
        check("mis_fault", {31'b0, fault}, 32'd0);
        wait_req(10);
        check("mis_addr", mem_addr, 32'h200);
        exp_pc = 32'h200;
`endif
        expect_stream(2, 20, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
